mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scans a channel range on a downstream mux tree and captures one sample per channel.
// Latency: a sel change yields out_valid after MUX_LAT+1 edges; min channel period MUX_LAT+2.
// Backpressure: holds sample, channel and sel while out_valid && !out_ready; stop aborts at once.
//
// Ports:
//   clk, rst_n          clock; synchronous active-high reset (despite the suffix)
//   start, stop         begin a scan (IDLE only) / abort from any state
//   continuous          repeat the range until stop (sampled at start)
//   first_ch, last_ch   scan range, wraps through 2**SEL_W-1 when first_ch > last_ch
//   sel, mux_out        channel select to the mux tree and the data it returns
//   out_data, out_ch    captured sample and its channel, qualified by out_valid
//   out_valid/out_ready sample handshake
//   busy, done          not-IDLE flag / one-cycle end-of-single-pass pulse
module mux_scan_ctrl #(
  parameter int WIDTH   = 8,
  parameter int SEL_W   = 6,
  parameter int MUX_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic [SEL_W-1:0] first_ch,
  input  logic [SEL_W-1:0] last_ch,
  output logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Settle counter is sized for the full 0..7 latency range.
  localparam logic [2:0] LAT = 3'(MUX_LAT);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0] first_q, first_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             cont_q, cont_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      cont_q  <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      last_q  <= last_d;
      cont_q  <= cont_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    last_d  = last_q;
    cont_d  = cont_q;
    data_d  = data_q;
    ch_d    = ch_q;
    vld_d   = vld_q;
    done_d  = 1'b0;

    if (stop) begin
      // Abort beats start and a same-cycle handshake; sel is left where it was
      // and any unaccepted sample is dropped.
      state_d = IDLE;
      vld_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            first_d = first_ch;
            last_d  = last_ch;
            cont_d  = continuous;
            sel_d   = first_ch;
            cnt_d   = LAT;
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == 3'd0) begin
            data_d  = mux_out;
            ch_d    = sel_q;
            vld_d   = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        HOLD: begin
          if (vld_q && out_ready) begin
            vld_d = 1'b0;
            if (sel_q != last_q) begin
              // Natural modulo wrap of sel handles first_ch > last_ch ranges.
              sel_d   = sel_q + 1'b1;
              cnt_d   = LAT;
              state_d = SETTLE;
            end else if (cont_q) begin
              sel_d   = first_q;
              cnt_d   = LAT;
              state_d = SETTLE;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = vld_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one instance with MUX_LAT=0, one with MUX_LAT=2.
// Inputs change and outputs are sampled on the falling clock edge.
// The mux tree is modelled as a fixed function of sel, optionally perturbed by noise.
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst;
  int         n_chk;
  int         n_err;

  // Instance with MUX_LAT=0
  logic       start0, stop0, cont0, ready0;
  logic [5:0] first0, last0;
  logic [5:0] sel0, out_ch0;
  logic [7:0] mux_out0, out_data0;
  logic       valid0, busy0, done0;

  // Instance with MUX_LAT=2
  logic       start2, stop2, cont2, ready2;
  logic [5:0] first2, last2;
  logic [5:0] sel2, out_ch2;
  logic [7:0] mux_out2, out_data2, noise;
  logic       valid2, busy2, done2;

  logic [5:0] ch_t;

  function automatic logic [7:0] fn(input logic [5:0] s);
    return {2'b10, s} ^ 8'h33;
  endfunction

  assign mux_out0 = fn(sel0);
  assign mux_out2 = fn(sel2) ^ noise;

  mux_scan_ctrl #(.WIDTH(8), .SEL_W(6), .MUX_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst), .start(start0), .stop(stop0), .continuous(cont0),
    .first_ch(first0), .last_ch(last0), .sel(sel0), .mux_out(mux_out0),
    .out_data(out_data0), .out_ch(out_ch0), .out_valid(valid0),
    .out_ready(ready0), .busy(busy0), .done(done0)
  );

  mux_scan_ctrl #(.WIDTH(8), .SEL_W(6), .MUX_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst), .start(start2), .stop(stop2), .continuous(cont2),
    .first_ch(first2), .last_ch(last2), .sel(sel2), .mux_out(mux_out2),
    .out_data(out_data2), .out_ch(out_ch2), .out_valid(valid2),
    .out_ready(ready2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Single-pass scan on the MUX_LAT=2 instance with out_ready high.
  // With inj set, start is re-asserted with a different range while busy.
  task automatic run_scan(input logic [5:0] f, input logic [5:0] l, input bit inj);
    logic [5:0] ch;
    logic [5:0] span;
    int         n;
    first2 = f; last2 = l; cont2 = 1'b0; ready2 = 1'b1; start2 = 1'b1;
    step();
    start2 = 1'b0;
    if (inj) begin
      first2 = 6'd50; last2 = 6'd51; cont2 = 1'b1;
    end
    span = l - f;
    n = int'(span) + 1;
    ch = f;
    for (int k = 0; k < n; k++) begin
      chk("scan_sel", 32'(sel2), 32'(ch));
      chk("scan_vld_lo", 32'(valid2), 0);
      start2 = inj;
      step();
      step();
      chk("scan_vld_early", 32'(valid2), 0);
      step();
      start2 = 1'b0;
      chk("scan_vld", 32'(valid2), 1);
      chk("scan_ch", 32'(out_ch2), 32'(ch));
      chk("scan_data", 32'(out_data2), 32'(fn(ch)));
      chk("scan_done_lo", 32'(done2), 0);
      step();
      ch = ch + 6'd1;
    end
    chk("scan_done", 32'(done2), 1);
    chk("scan_busy_end", 32'(busy2), 0);
    chk("scan_sel_end", 32'(sel2), 32'(l));
    chk("scan_vld_end", 32'(valid2), 0);
    cont2 = 1'b0;
    step();
    chk("scan_done_pulse", 32'(done2), 0);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b1; noise = 8'h00;
    start0 = 0; stop0 = 0; cont0 = 0; ready0 = 1; first0 = 0; last0 = 0;
    start2 = 0; stop2 = 0; cont2 = 0; ready2 = 1; first2 = 0; last2 = 0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_sel", 32'(sel2), 0);
    chk("rst_data", 32'(out_data2), 0);
    chk("rst_ch", 32'(out_ch2), 0);
    chk("rst_vld", 32'(valid2), 0);
    chk("rst_busy", 32'(busy2), 0);
    chk("rst_done", 32'(done2), 0);
    chk("rst_busy0", 32'(busy0), 0);

    // MUX_LAT=0, channels 3..5, one sample every second cycle
    first0 = 6'd3; last0 = 6'd5; cont0 = 0; ready0 = 1; start0 = 1;
    step();
    start0 = 0;
    ch_t = 6'd3;
    for (int k = 0; k < 3; k++) begin
      chk("t1_sel", 32'(sel0), 32'(ch_t));
      chk("t1_vld_lo", 32'(valid0), 0);
      chk("t1_done_lo", 32'(done0), 0);
      step();
      chk("t1_vld", 32'(valid0), 1);
      chk("t1_ch", 32'(out_ch0), 32'(ch_t));
      chk("t1_data", 32'(out_data0), 32'(fn(ch_t)));
      chk("t1_busy", 32'(busy0), 1);
      step();
      ch_t = ch_t + 6'd1;
    end
    chk("t1_done", 32'(done0), 1);
    chk("t1_busy_end", 32'(busy0), 0);
    chk("t1_sel_end", 32'(sel0), 5);
    step();
    chk("t1_done_pulse", 32'(done0), 0);
    chk("t1_busy_after", 32'(busy0), 0);

    // MUX_LAT=2, wrapping range 62..1
    run_scan(6'd62, 6'd1, 1'b0);

    // Backpressure: out_ready low for 10 cycles while mux_out moves
    first2 = 6'd10; last2 = 6'd11; cont2 = 0; ready2 = 0; start2 = 1;
    step();
    start2 = 0;
    step(); step(); step();
    chk("bp_vld", 32'(valid2), 1);
    chk("bp_ch0", 32'(out_ch2), 10);
    for (int i = 0; i < 10; i++) begin
      noise = 8'(i + 1);
      step();
      chk("bp_hold_data", 32'(out_data2), 32'(fn(6'd10)));
      chk("bp_hold_ch", 32'(out_ch2), 10);
      chk("bp_hold_sel", 32'(sel2), 10);
      chk("bp_hold_vld", 32'(valid2), 1);
    end
    noise = 8'h00;
    ready2 = 1;
    step();
    ready2 = 0;
    chk("bp_adv_sel", 32'(sel2), 11);
    chk("bp_adv_vld", 32'(valid2), 0);
    step(); step(); step();
    chk("bp_ch1", 32'(out_ch2), 11);
    chk("bp_data1", 32'(out_data2), 32'(fn(6'd11)));
    ready2 = 1;
    step();
    chk("bp_done", 32'(done2), 1);
    step();

    // Continuous single-channel scan, then stop coincident with a handshake
    first2 = 6'd7; last2 = 6'd7; cont2 = 1; ready2 = 1; start2 = 1;
    step();
    start2 = 0;
    for (int k = 0; k < 3; k++) begin
      step(); step(); step();
      chk("cont_vld", 32'(valid2), 1);
      chk("cont_ch", 32'(out_ch2), 7);
      step();
      chk("cont_vld_lo", 32'(valid2), 0);
      chk("cont_sel", 32'(sel2), 7);
      chk("cont_busy", 32'(busy2), 1);
      chk("cont_done_lo", 32'(done2), 0);
    end
    step(); step(); step();
    chk("stop_pre_vld", 32'(valid2), 1);
    stop2 = 1;
    step();
    stop2 = 0;
    chk("stop_busy", 32'(busy2), 0);
    chk("stop_vld", 32'(valid2), 0);
    chk("stop_done", 32'(done2), 0);
    chk("stop_sel", 32'(sel2), 7);
    step();
    chk("stop_done_after", 32'(done2), 0);
    chk("stop_busy_after", 32'(busy2), 0);

    // Reset during SETTLE of the third channel
    first2 = 6'd20; last2 = 6'd30; cont2 = 0; ready2 = 1; start2 = 1;
    step();
    start2 = 0;
    for (int k = 0; k < 8; k++) step();
    chk("mid_sel", 32'(sel2), 22);
    chk("mid_vld", 32'(valid2), 0);
    rst = 1;
    step();
    rst = 0;
    chk("mrst_sel", 32'(sel2), 0);
    chk("mrst_data", 32'(out_data2), 0);
    chk("mrst_ch", 32'(out_ch2), 0);
    chk("mrst_vld", 32'(valid2), 0);
    chk("mrst_busy", 32'(busy2), 0);
    chk("mrst_done", 32'(done2), 0);
    step();
    chk("mrst_idle", 32'(busy2), 0);
    run_scan(6'd40, 6'd41, 1'b0);

    // start while busy with a different range is ignored
    run_scan(6'd2, 6'd4, 1'b1);
    step();
    chk("inj_idle", 32'(busy2), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
